uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial UART transmitter; the transmit-side counterpart of the team's uart_rx.
- Frame format: 1 start bit (0), DATA_WIDTH data bits LSB first, optional even-parity bit, 1 or 2 stop bits (1).
- Accepts parallel words over a valid/ready handshake into a one-entry holding buffer, so back-to-back frames go out with no idle gap.
- Line timing comes from the shared external baud_tick strobe: one bit period per baud_tick.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9)
PARITY_EN, 1, 1 = append even-parity bit (XOR of data bits); 0 = no parity bit
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock; the block's only clock
rst_n  input  1  asynchronous, active-low reset
baud_tick  input  1  one-clk strobe per bit period
tx_valid  input  1  tx_data is valid for transfer
tx_data  input  DATA_WIDTH  word to transmit
tx_ready  output  1  holding buffer empty; transfer happens when tx_valid && tx_ready
tx_serial  output  1  serial line, idles high, registered
tx_busy  output  1  frame in progress (state != IDLE)
tx_done  output  1  one-clk pulse when the final stop bit period ends

Behaviour:
- Reset: the only clock is clk; reset is asynchronous and active-low. While rst_n=0 and after release: tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, holding buffer empty, counters 0.
- Reset mid-frame aborts the frame: the line returns high immediately and any buffered word is discarded.
- States: IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT. Each state names the bit currently on tx_serial.
- State, tx_serial and counters change only on clk edges with baud_tick=1, except the handshake logic.
- Handshake, evaluated every clk regardless of baud_tick:
  - tx_ready = !buf_full, combinational from the register.
  - When tx_valid && tx_ready: capture tx_data and set buf_full on that edge.
  - tx_data may change freely after the transfer.
- Frame load: on a baud_tick edge in IDLE with buf_full=1:
  - copy buffer to shift register; compute parity = ^data.
  - clear buf_full; tx_serial<=0; go to START_BIT.
  - tx_ready rises on the following clk.
- START_BIT, on baud_tick: tx_serial<=shift[0], bit_cnt<=0, go to DATA_BITS.
- DATA_BITS, on baud_tick:
  - if bit_cnt == DATA_WIDTH-1: go to PARITY_BIT with tx_serial<=parity, or, if PARITY_EN=0, go to STOP_BIT with tx_serial<=1.
  - otherwise: shift right, tx_serial<=next bit, bit_cnt++.
- PARITY_BIT, on baud_tick: tx_serial<=1, stop_cnt<=0, go to STOP_BIT.
- STOP_BIT, on baud_tick:
  - if stop_cnt < STOP_BITS-1: stop_cnt++ and remain.
  - otherwise pulse tx_done for that clk, then:
    - if buf_full: load the next word and go to START_BIT with tx_serial<=0 (no idle bit).
    - else: go to IDLE with tx_serial<=1.
- A word accepted in the same clk as a STOP_BIT-final baud_tick is not seen by that edge. It starts on the next baud_tick from IDLE.
- Latency: first 0 on the line at the first baud_tick after acceptance.
- Frame length in baud_ticks: 1 + DATA_WIDTH + PARITY_EN + STOP_BITS.
- With baud_tick held low the state is frozen. One more word can still be accepted; tx_ready then stays 0.
- tx_busy = (state != IDLE). It stays 1 across back-to-back frames.
- Parity matches uart_rx: even, i.e. the parity bit equals XOR of the data bits.
- bit_cnt is wide enough for DATA_WIDTH-1 and never wraps within a frame.

Test Plan:
1. Basic frame: DATA_WIDTH=8; send 0xA5 -> tx_serial per baud_tick: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. tx_done pulses once at the end of the stop bit; tx_busy=0 afterwards.
2. Odd parity count: send 0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit 1. With PARITY_EN=0 the frame is 10 ticks and has no parity bit.
3. Back-to-back:
   - send 0x55, and 0xAA while 0x55 is shifting.
   - tx_ready=0 after the 2nd accept.
   - 0xAA's start bit immediately follows 0x55's stop bit.
   - tx_busy stays 1 for 22 ticks; tx_done pulses twice.
4. STOP_BITS=2: send 0x3C -> line held 1 for two ticks after parity; tx_done only after the second stop tick.
5. Reset mid-frame:
   - assert rst_n=0 during data bit 3 of 0xF0 with 0x0F buffered -> tx_serial=1 and tx_ready=1 immediately.
   - after release there is no transmission until a new transfer.
6. Loopback with uart_rx:
   - transmit random 200 words at a shared baud_tick.
   - uart_rx reports data_valid with matching data_out for every word.
   - no parity or stop errors reported.

Source files
------------

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- serial UART transmitter
//
// Sends frames of: 1 start bit (0), DATA_WIDTH data bits LSB first,
// an optional even-parity bit, then STOP_BITS stop bits (1). One bit period
// lasts from one baud_tick to the next. A one-entry holding buffer in front
// of the shifter lets the next word wait while the current frame is on the
// line, so consecutive frames go out with no idle bit between them.
//
// Parameters:
//   DATA_WIDTH  data bits per frame (5..9)
//   PARITY_EN   1 = append even-parity bit (XOR of data bits), 0 = none
//   STOP_BITS   number of stop bits (1 or 2)
//
// Ports:
//   clk        in   system clock, the only clock
//   rst_n      in   asynchronous active-low reset
//   baud_tick  in   one-clk strobe per bit period
//   tx_valid   in   tx_data valid for transfer
//   tx_data    in   word to transmit
//   tx_ready   out  holding buffer empty (transfer when tx_valid && tx_ready)
//   tx_serial  out  serial line, idles high, registered
//   tx_busy    out  frame in progress
//   tx_done    out  one-clk pulse after the final stop bit period ends
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  baud_tick,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx_serial,
    output logic                  tx_busy,
    output logic                  tx_done
);

    // bit_cnt only has to reach DATA_WIDTH-1, so it never wraps in a frame.
    localparam int                CNT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    // stop_cnt value in the last stop bit period (0 for one stop bit, 1 for two).
    localparam logic              LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    // Each state names the bit currently driven on tx_serial.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity: the parity bit equals the XOR of all data bits, matching uart_rx.
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] data);
        return ^data;
    endfunction

    // Registered state
    state_t                  state_r;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic [CNT_W-1:0]        bit_cnt_r;
    logic                    stop_cnt_r;
    logic                    parity_r;
    logic                    serial_r;
    logic                    done_r;
    logic                    buf_full_r;
    logic [DATA_WIDTH-1:0]   buf_data_r;

    // Next-state values
    state_t                  state_s;
    logic [DATA_WIDTH-1:0]   shift_s;
    logic [CNT_W-1:0]        bit_cnt_s;
    logic                    stop_cnt_s;
    logic                    parity_s;
    logic                    serial_s;
    logic                    done_s;
    logic                    load_s;
    logic                    accept_s;

    // A transfer only happens into an empty buffer, so accept and load never coincide.
    assign accept_s = tx_valid & ~buf_full_r;

    // Holding buffer: capture on handshake, release when the shifter loads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full_r <= 1'b0;
            buf_data_r <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            buf_full_r <= 1'b1;
            buf_data_r <= tx_data;
        end else if (load_s) begin
            buf_full_r <= 1'b0;
        end else begin
            buf_full_r <= buf_full_r;
        end
    end

    // Frame FSM registers and the registered line/done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            shift_r    <= {DATA_WIDTH{1'b0}};
            bit_cnt_r  <= {CNT_W{1'b0}};
            stop_cnt_r <= 1'b0;
            parity_r   <= 1'b0;
            serial_r   <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            bit_cnt_r  <= bit_cnt_s;
            stop_cnt_r <= stop_cnt_s;
            parity_r   <= parity_s;
            serial_r   <= serial_s;
            done_r     <= done_s;
        end
    end

    // Next-state logic: everything advances only on baud_tick.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        bit_cnt_s  = bit_cnt_r;
        stop_cnt_s = stop_cnt_r;
        parity_s   = parity_r;
        serial_s   = serial_r;
        done_s     = 1'b0;
        load_s     = 1'b0;

        if (baud_tick) begin
            case (state_r)
                ST_IDLE: begin
                    if (buf_full_r) begin
                        load_s   = 1'b1;
                        shift_s  = buf_data_r;
                        parity_s = even_parity(buf_data_r);
                        serial_s = 1'b0;
                        state_s  = ST_START;
                    end else begin
                        serial_s = 1'b1;
                    end
                end

                ST_START: begin
                    serial_s  = shift_r[0];
                    bit_cnt_s = {CNT_W{1'b0}};
                    state_s   = ST_DATA;
                end

                ST_DATA: begin
                    if (bit_cnt_r == LAST_BIT) begin
                        if (PARITY_EN) begin
                            serial_s = parity_r;
                            state_s  = ST_PARITY;
                        end else begin
                            serial_s   = 1'b1;
                            stop_cnt_s = 1'b0;
                            state_s    = ST_STOP;
                        end
                    end else begin
                        // shift_r[0] is on the line now; bit 1 is next.
                        shift_s   = {1'b0, shift_r[DATA_WIDTH-1:1]};
                        serial_s  = shift_r[1];
                        bit_cnt_s = bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end

                ST_PARITY: begin
                    serial_s   = 1'b1;
                    stop_cnt_s = 1'b0;
                    state_s    = ST_STOP;
                end

                ST_STOP: begin
                    if (stop_cnt_r != LAST_STOP) begin
                        stop_cnt_s = 1'b1;
                    end else begin
                        done_s = 1'b1;
                        if (buf_full_r) begin
                            // Chain straight into the next start bit, no idle period.
                            load_s   = 1'b1;
                            shift_s  = buf_data_r;
                            parity_s = even_parity(buf_data_r);
                            serial_s = 1'b0;
                            state_s  = ST_START;
                        end else begin
                            serial_s = 1'b1;
                            state_s  = ST_IDLE;
                        end
                    end
                end

                default: begin
                    serial_s = 1'b1;
                    state_s  = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    assign tx_ready  = ~buf_full_r;
    assign tx_serial = serial_r;
    assign tx_busy   = (state_r != ST_IDLE);
    assign tx_done   = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- directed testbench for uart_tx
//
// Three instances share clk, rst_n, baud_tick and tx_data:
//   u0: 8 data bits, even parity, 1 stop bit
//   u1: 8 data bits, no parity,   1 stop bit
//   u2: 8 data bits, even parity, 2 stop bits
// Expected frames are hand-computed and packed with bit i = line value
// sampled after the i-th baud_tick following acceptance.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       baud_tick;
    logic [2:0] vld;
    logic [7:0] tx_data;
    logic [2:0] rdy;
    logic [2:0] ser;
    logic [2:0] busy;
    logic [2:0] done;

    int total;
    int bad;

    // Per-tick capture vectors
    logic [31:0] s0, s1, s2, d0, d1, d2, b0;

    uart_tx #(.DATA_WIDTH(8), .PARITY_EN(1'b1), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
        .tx_valid(vld[0]), .tx_data(tx_data), .tx_ready(rdy[0]),
        .tx_serial(ser[0]), .tx_busy(busy[0]), .tx_done(done[0])
    );

    uart_tx #(.DATA_WIDTH(8), .PARITY_EN(1'b0), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
        .tx_valid(vld[1]), .tx_data(tx_data), .tx_ready(rdy[1]),
        .tx_serial(ser[1]), .tx_busy(busy[1]), .tx_done(done[1])
    );

    uart_tx #(.DATA_WIDTH(8), .PARITY_EN(1'b1), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
        .tx_valid(vld[2]), .tx_data(tx_data), .tx_ready(rdy[2]),
        .tx_serial(ser[2]), .tx_busy(busy[2]), .tx_done(done[2])
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One baud period: strobe for one clk, sample half a clk after the edge.
    task automatic tick();
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
    endtask

    // Run n ticks, recording samples at positions start..start+n-1.
    task automatic capture(input int start, input int n);
        for (int i = start; i < start + n; i++) begin
            tick();
            s0[i] = ser[0];
            s1[i] = ser[1];
            s2[i] = ser[2];
            d0[i] = done[0];
            d1[i] = done[1];
            d2[i] = done[2];
            b0[i] = busy[0];
        end
    endtask

    // Transfer one word into every instance selected by mask (bounded wait).
    task automatic push(input logic [2:0] mask, input logic [7:0] data);
        int waited;
        waited = 0;
        while (((rdy & mask) != mask) && (waited < 20)) begin
            @(negedge clk);
            waited++;
        end
        check("push_ready_timeout", 32'(waited < 20), 32'd1);
        tx_data = data;
        vld     = mask;
        @(negedge clk);
        vld     = 3'b000;
        tx_data = 8'h00;
    endtask

    initial begin
        int         rx_cnt;
        int         pushed;
        int         budget;
        int         rx_phase;
        logic [7:0] rx_word;
        logic [7:0] words[$];
        logic [7:0] w;

        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        baud_tick = 1'b0;
        vld       = 3'b000;
        tx_data   = 8'h00;
        s0 = '0; s1 = '0; s2 = '0; d0 = '0; d1 = '0; d2 = '0; b0 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_serial", 32'(ser), 32'h7);
        check("rst_ready",  32'(rdy), 32'h7);
        check("rst_busy",   32'(busy), 32'h0);
        check("rst_done",   32'(done), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        capture(0, 2);
        check("idle_line", s0[1:0], 32'h3);
        check("idle_ready", 32'(rdy), 32'h7);

        // 1: 0xA5 -> 0,1,0,1,0,0,1,0,1, parity 0, stop 1
        push(3'b001, 8'hA5);
        capture(0, 13);
        check("a5_frame", 32'(s0[10:0]), 32'h54A);
        check("a5_after", 32'(s0[12:11]), 32'h3);
        check("a5_done",  32'(d0[12:0]), 32'h0800);
        check("a5_busy",  32'(b0[12:0]), 32'h07FF);

        // 2: 0x07 with parity (parity 1) and without parity (10 ticks)
        push(3'b011, 8'h07);
        capture(0, 12);
        check("07_par_frame", 32'(s0[10:0]), 32'h60E);
        check("07_par_done",  32'(d0[11:0]), 32'h800);
        check("07_np_frame",  32'(s1[9:0]),  32'h20E);
        check("07_np_after",  32'(s1[11:10]), 32'h3);
        check("07_np_done",   32'(d1[11:0]), 32'h400);

        // 3: back-to-back 0x55 then 0xAA
        push(3'b001, 8'h55);
        capture(0, 3);
        push(3'b001, 8'hAA);
        check("b2b_ready_low", 32'(rdy[0]), 32'h0);
        capture(3, 21);
        check("b2b_frames", 32'(s0[21:0]), {10'h0, 11'h554, 11'h4AA});
        check("b2b_busy",   32'(b0[23:0]), 32'h3FFFFF);
        check("b2b_done",   32'(d0[23:0]), 32'h400800);
        check("b2b_ready_end", 32'(rdy[0]), 32'h1);

        // 4: two stop bits, 0x3C
        push(3'b100, 8'h3C);
        capture(0, 14);
        check("s2_frame", 32'(s2[11:0]), 32'hC78);
        check("s2_done",  32'(d2[13:0]), 32'h1000);
        check("s2_after", 32'(s2[13:12]), 32'h3);

        // 5: reset during data bit 3 of 0xF0 with 0x0F buffered
        push(3'b001, 8'hF0);
        capture(0, 2);
        push(3'b001, 8'h0F);
        capture(2, 3);
        check("rstmid_prefix", 32'(s0[4:0]), 32'h00);
        check("rstmid_ready_before", 32'(rdy[0]), 32'h0);
        rst_n = 1'b0;
        #1;
        check("rstmid_serial", 32'(ser[0]), 32'h1);
        check("rstmid_ready",  32'(rdy[0]), 32'h1);
        check("rstmid_busy",   32'(busy[0]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        capture(0, 15);
        check("rstmid_quiet_line", 32'(s0[14:0]), 32'h7FFF);
        check("rstmid_quiet_busy", 32'(b0[14:0]), 32'h0);
        check("rstmid_quiet_done", 32'(d0[14:0]), 32'h0);

        // 6: loopback of 200 random words through a bench-side receiver
        for (int i = 0; i < 200; i++) begin
            w = 8'($urandom_range(0, 255));
            words.push_back(w);
        end
        rx_cnt   = 0;
        pushed   = 0;
        budget   = 0;
        rx_phase = 0;
        rx_word  = 8'h00;
        while ((rx_cnt < 200) && (budget < 3000)) begin
            if (rdy[0] && (pushed < 200)) begin
                tx_data = words[pushed];
                vld     = 3'b001;
                @(negedge clk);
                vld     = 3'b000;
                pushed++;
            end
            tick();
            budget++;
            // rx_phase: 0 idle, 1..8 data bits, 9 parity, 10 stop
            if (rx_phase == 0) begin
                if (ser[0] == 1'b0) rx_phase = 1;
            end else if (rx_phase <= 8) begin
                rx_word[rx_phase-1] = ser[0];
                rx_phase++;
            end else if (rx_phase == 9) begin
                check("lb_parity", 32'(ser[0]), 32'(^rx_word));
                rx_phase = 10;
            end else begin
                check("lb_stop", 32'(ser[0]), 32'h1);
                check("lb_data", 32'(rx_word), 32'(words[rx_cnt]));
                rx_cnt++;
                rx_phase = 0;
            end
        end
        check("lb_count", 32'(rx_cnt), 32'd200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
